pipeline_fetch_ctrl: RTL and testbench

//  Sequences the PC register and the instruction-memory port for the pipelined core.

---
 rtl/pipeline_fetch_ctrl_if.sv | 16 +
 rtl/pipeline_fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_fetch_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_fetch_ctrl_if.sv
// Instruction-memory read port between the fetch controller and imem.
//  master : fetch controller (drives address/read mask, receives data/resp)
//  slave  : instruction memory
//  imem_addr   32  read address
//  imem_rmask   4  4'hF = read request active, 4'h0 = idle
//  imem_rdata  32  read data, valid when imem_resp=1
//  imem_resp    1  response strobe
interface pipeline_fetch_ctrl_if;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;

   modport master (output imem_addr, imem_rmask, input imem_rdata, imem_resp);
   modport slave  (input imem_addr, imem_rmask, output imem_rdata, imem_resp);
endinterface

// File: rtl/pipeline_fetch_ctrl.sv
// pipeline_fetch_ctrl
// Sequences PC / instruction-memory fetch for the pipelined core. One imem
// read is outstanding at a time; the PC register is held (pc_stall) until the
// word is accepted. Redirects (trap > branch mispredict) are merged into one
// redirect_en/redirect_pc pulse. Fetched words go to decode through a 1-entry
// output register backed by a 1-entry skid buffer.
//
// Optional feature: define FETCH_REDIRECT_COUNT_EN to add redirect_count, a
// CNT_W-bit wrapping count of cycles with redirect_en=1.
//
// Ports
//  clk, rst_n              clock, asynchronous active-low reset
//  pc                      current PC from the PC register
//  pc_stall                1 = PC register holds
//  redirect_en/redirect_pc redirect pulse and target to the PC register
//  imem                    imem read port (master side)
//  ir_valid/ir/ir_pc       fetched word to decode
//  backend_stall           decode not accepting
//  br_mispredict/br_target mispredict redirect request
//  trap_en/trap_vector     trap redirect request
//  redirect_count          redirect counter (FETCH_REDIRECT_COUNT_EN only)
module pipeline_fetch_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   output logic        pc_stall,
   output logic        redirect_en,
   output logic [31:0] redirect_pc,
   pipeline_fetch_ctrl_if.master imem,
   output logic        ir_valid,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   input  logic        backend_stall,
   input  logic        br_mispredict,
   input  logic [31:0] br_target,
   input  logic        trap_en,
   input  logic [31:0] trap_vector
`ifdef FETCH_REDIRECT_COUNT_EN
   ,
   output logic [CNT_W-1:0] redirect_count
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

   state_t      state, state_nxt;
   logic [31:0] req_addr;
   logic [31:0] skid, skid_pc;
   logic        redir, slot_free;
   logic        load_fetch, load_skid, load_hold;

   // ------------------------------------------------------------------
   // Next state, handshake outputs, datapath load enables
   // ------------------------------------------------------------------
   always_comb begin
      redir            = trap_en | br_mispredict;
      redirect_en      = redir;
      redirect_pc      = trap_en ? trap_vector : br_target;
      slot_free        = ~ir_valid | ~backend_stall;
      state_nxt        = state;
      pc_stall         = 1'b1;
      imem.imem_addr   = req_addr;
      imem.imem_rmask  = 4'h0;
      load_fetch       = 1'b0;
      load_skid        = 1'b0;
      load_hold        = 1'b0;
      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            imem.imem_addr  = pc;
            imem.imem_rmask = 4'hF;
            if (redir) begin
               // Response in the redirect cycle is simply dropped; without
               // one, the stale request must still be drained.
               if (!imem.imem_resp) state_nxt = DROP;
            end else if (imem.imem_resp) begin
               pc_stall = 1'b0;
               if (slot_free) begin
                  load_fetch = 1'b1;
               end else begin
                  load_skid = 1'b1;
                  state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            // A redirect flushes the skid word; no request is outstanding,
            // so fetching resumes directly at the new PC.
            if (redir) begin
               state_nxt = FETCH;
            end else if (slot_free) begin
               load_hold = 1'b1;
               state_nxt = FETCH;
            end
         end
         DROP: begin
            // Address held at the original request until its response.
            imem.imem_rmask = 4'hF;
            if (imem.imem_resp) state_nxt = FETCH;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         req_addr <= 32'h0;
         ir_valid <= 1'b0;
         ir       <= 32'h0;
         ir_pc    <= 32'h0;
         skid     <= 32'h0;
         skid_pc  <= 32'h0;
      end else begin
         state <= state_nxt;
         if (state == FETCH) req_addr <= pc;

         if (redir)                       ir_valid <= 1'b0;
         else if (load_fetch | load_hold) ir_valid <= 1'b1;
         else if (ir_valid & ~backend_stall) ir_valid <= 1'b0;

         if (load_fetch) begin
            ir    <= imem.imem_rdata;
            ir_pc <= pc;
         end else if (load_hold) begin
            ir    <= skid;
            ir_pc <= skid_pc;
         end

         if (load_skid) begin
            skid    <= imem.imem_rdata;
            skid_pc <= pc;
         end
      end
   end

`ifdef FETCH_REDIRECT_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     redirect_count <= '0;
      else if (redir) redirect_count <= redirect_count + 1'b1;
   end
`else
   // CNT_W only sizes the optional counter; nothing to build without it.
   if (CNT_W < 1) begin : g_no_counter
   end
`endif

endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// Directed bench for pipeline_fetch_ctrl. Inputs change just after negedge;
// outputs are sampled 1 time unit later, well away from posedge.
module tb_pipeline_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        pc_stall, redirect_en, ir_valid;
   logic [31:0] redirect_pc, ir, ir_pc;
   logic        backend_stall, br_mispredict, trap_en;
   logic [31:0] br_target, trap_vector;
`ifdef FETCH_REDIRECT_COUNT_EN
   logic [31:0] redirect_count;
`endif
   int tests = 0;
   int failed = 0;

   pipeline_fetch_ctrl_if imem ();

   pipeline_fetch_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .pc_stall(pc_stall),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc), .imem(imem),
      .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .backend_stall(backend_stall),
      .br_mispredict(br_mispredict), .br_target(br_target),
      .trap_en(trap_en), .trap_vector(trap_vector)
`ifdef FETCH_REDIRECT_COUNT_EN
      , .redirect_count(redirect_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; pc = 32'h6000_0000; backend_stall = 1'b0;
      br_mispredict = 1'b0; br_target = 32'h0; trap_en = 1'b0; trap_vector = 32'h0;
      imem.imem_resp = 1'b0; imem.imem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL rst_ir_valid: got %0h want 0", ir_valid); end
      tests++; if (ir !== 32'h0) begin failed++; $display("FAIL rst_ir: got %h want 0", ir); end
      tests++; if (ir_pc !== 32'h0) begin failed++; $display("FAIL rst_ir_pc: got %h want 0", ir_pc); end
      tests++; if (pc_stall !== 1'b1) begin failed++; $display("FAIL rst_pc_stall: got %0h want 1", pc_stall); end
      tests++; if (redirect_en !== 1'b0) begin failed++; $display("FAIL rst_redirect_en: got %0h want 0", redirect_en); end
      tests++; if (redirect_pc !== 32'h0) begin failed++; $display("FAIL rst_redirect_pc: got %h want 0", redirect_pc); end
      tests++; if (imem.imem_rmask !== 4'h0) begin failed++; $display("FAIL rst_rmask: got %h want 0", imem.imem_rmask); end
      tests++; if (imem.imem_addr !== 32'h0) begin failed++; $display("FAIL rst_addr: got %h want 0", imem.imem_addr); end
`ifdef FETCH_REDIRECT_COUNT_EN
      tests++; if (redirect_count !== 32'h0) begin failed++; $display("FAIL rst_count: got %0d want 0", redirect_count); end
`endif
      @(negedge clk); rst_n = 1'b1; #1;
      tests++; if (imem.imem_rmask !== 4'h0) begin failed++; $display("FAIL idle_rmask: got %h want 0", imem.imem_rmask); end
      tests++; if (pc_stall !== 1'b1) begin failed++; $display("FAIL idle_pc_stall: got %0h want 1", pc_stall); end
   endtask

   task automatic test_fetch();
      @(negedge clk); #1;
      tests++; if (imem.imem_rmask !== 4'hF) begin failed++; $display("FAIL fetch_rmask: got %h want f", imem.imem_rmask); end
      tests++; if (imem.imem_addr !== 32'h6000_0000) begin failed++; $display("FAIL fetch_addr: got %h want 60000000", imem.imem_addr); end
      tests++; if (pc_stall !== 1'b1) begin failed++; $display("FAIL fetch_stall_req: got %0h want 1", pc_stall); end
      @(negedge clk); #1;
      tests++; if (pc_stall !== 1'b1) begin failed++; $display("FAIL fetch_stall_wait: got %0h want 1", pc_stall); end
      @(negedge clk); imem.imem_resp = 1'b1; imem.imem_rdata = 32'h0000_0013; #1;
      tests++; if (pc_stall !== 1'b0) begin failed++; $display("FAIL fetch_stall_resp: got %0h want 0", pc_stall); end
      tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL fetch_early_valid: got %0h want 0", ir_valid); end
      @(negedge clk); imem.imem_resp = 1'b0; pc = 32'h6000_0004; #1;
      tests++; if (ir_valid !== 1'b1) begin failed++; $display("FAIL fetch_ir_valid: got %0h want 1", ir_valid); end
      tests++; if (ir !== 32'h0000_0013) begin failed++; $display("FAIL fetch_ir: got %h want 00000013", ir); end
      tests++; if (ir_pc !== 32'h6000_0000) begin failed++; $display("FAIL fetch_ir_pc: got %h want 60000000", ir_pc); end
      tests++; if (pc_stall !== 1'b1) begin failed++; $display("FAIL fetch_stall_after: got %0h want 1", pc_stall); end
      tests++; if (imem.imem_addr !== 32'h6000_0004) begin failed++; $display("FAIL fetch_next_addr: got %h want 60000004", imem.imem_addr); end
   endtask

   task automatic test_skid();
      @(negedge clk); imem.imem_resp = 1'b1; imem.imem_rdata = 32'h0010_0093; #1;
      tests++; if (pc_stall !== 1'b0) begin failed++; $display("FAIL skid_stall_d1: got %0h want 0", pc_stall); end
      @(negedge clk); pc = 32'h6000_0008; backend_stall = 1'b1; imem.imem_rdata = 32'h0020_0113; #1;
      tests++; if (pc_stall !== 1'b0) begin failed++; $display("FAIL skid_stall_d2: got %0h want 0", pc_stall); end
      @(negedge clk); pc = 32'h6000_000C; imem.imem_resp = 1'b0; #1;
      tests++; if (imem.imem_rmask !== 4'h0) begin failed++; $display("FAIL hold_rmask: got %h want 0", imem.imem_rmask); end
      tests++; if (pc_stall !== 1'b1) begin failed++; $display("FAIL hold_stall: got %0h want 1", pc_stall); end
      tests++; if (ir !== 32'h0010_0093) begin failed++; $display("FAIL hold_ir: got %h want 00100093", ir); end
      tests++; if (ir_pc !== 32'h6000_0004) begin failed++; $display("FAIL hold_ir_pc: got %h want 60000004", ir_pc); end
      @(negedge clk); backend_stall = 1'b0; #1;
      tests++; if (imem.imem_rmask !== 4'h0) begin failed++; $display("FAIL hold_release_rmask: got %h want 0", imem.imem_rmask); end
      @(negedge clk); #1;
      tests++; if (ir !== 32'h0020_0113) begin failed++; $display("FAIL skid_ir: got %h want 00200113", ir); end
      tests++; if (ir_pc !== 32'h6000_0008) begin failed++; $display("FAIL skid_ir_pc: got %h want 60000008", ir_pc); end
      tests++; if (ir_valid !== 1'b1) begin failed++; $display("FAIL skid_ir_valid: got %0h want 1", ir_valid); end
      tests++; if (imem.imem_addr !== 32'h6000_000C) begin failed++; $display("FAIL skid_resume_addr: got %h want 6000000c", imem.imem_addr); end
      tests++; if (imem.imem_rmask !== 4'hF) begin failed++; $display("FAIL skid_resume_rmask: got %h want f", imem.imem_rmask); end
   endtask

   task automatic test_mispredict();
      @(negedge clk); br_mispredict = 1'b1; br_target = 32'h6000_0100; #1;
      tests++; if (redirect_en !== 1'b1) begin failed++; $display("FAIL mp_redirect_en: got %0h want 1", redirect_en); end
      tests++; if (redirect_pc !== 32'h6000_0100) begin failed++; $display("FAIL mp_redirect_pc: got %h want 60000100", redirect_pc); end
      tests++; if (pc_stall !== 1'b1) begin failed++; $display("FAIL mp_stall: got %0h want 1", pc_stall); end
      @(negedge clk); br_mispredict = 1'b0; pc = 32'h6000_0100; #1;
      tests++; if (redirect_en !== 1'b0) begin failed++; $display("FAIL mp_pulse_len: got %0h want 0", redirect_en); end
      tests++; if (imem.imem_addr !== 32'h6000_000C) begin failed++; $display("FAIL drop_addr: got %h want 6000000c", imem.imem_addr); end
      tests++; if (imem.imem_rmask !== 4'hF) begin failed++; $display("FAIL drop_rmask: got %h want f", imem.imem_rmask); end
      @(negedge clk); imem.imem_resp = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF; #1;
      tests++; if (pc_stall !== 1'b1) begin failed++; $display("FAIL drop_stall_resp: got %0h want 1", pc_stall); end
      @(negedge clk); imem.imem_resp = 1'b0; #1;
      tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL drop_stale_valid: got %0h want 0", ir_valid); end
      tests++; if (imem.imem_addr !== 32'h6000_0100) begin failed++; $display("FAIL mp_target_addr: got %h want 60000100", imem.imem_addr); end
`ifdef FETCH_REDIRECT_COUNT_EN
      tests++; if (redirect_count !== 32'd1) begin failed++; $display("FAIL mp_count: got %0d want 1", redirect_count); end
`endif
   endtask

   task automatic test_trap_flush();
      @(negedge clk); backend_stall = 1'b1; imem.imem_resp = 1'b1; imem.imem_rdata = 32'h0000_0011; #1;
      tests++; if (pc_stall !== 1'b0) begin failed++; $display("FAIL tf_stall_w1: got %0h want 0", pc_stall); end
      @(negedge clk); pc = 32'h6000_0104; imem.imem_rdata = 32'h0000_0022; #1;
      @(negedge clk); imem.imem_resp = 1'b0; trap_en = 1'b1; br_mispredict = 1'b1;
      trap_vector = 32'h6000_0800; br_target = 32'h6000_0200; #1;
      tests++; if (redirect_pc !== 32'h6000_0800) begin failed++; $display("FAIL tf_redirect_pc: got %h want 60000800", redirect_pc); end
      tests++; if (redirect_en !== 1'b1) begin failed++; $display("FAIL tf_redirect_en: got %0h want 1", redirect_en); end
      tests++; if (ir_valid !== 1'b1) begin failed++; $display("FAIL tf_pre_flush_valid: got %0h want 1", ir_valid); end
      tests++; if (imem.imem_rmask !== 4'h0) begin failed++; $display("FAIL tf_hold_rmask: got %h want 0", imem.imem_rmask); end
      @(negedge clk); trap_en = 1'b0; br_mispredict = 1'b0; pc = 32'h6000_0800; backend_stall = 1'b0; #1;
      tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL tf_flush_valid: got %0h want 0", ir_valid); end
      tests++; if (imem.imem_addr !== 32'h6000_0800) begin failed++; $display("FAIL tf_addr: got %h want 60000800", imem.imem_addr); end
      tests++; if (imem.imem_rmask !== 4'hF) begin failed++; $display("FAIL tf_rmask: got %h want f", imem.imem_rmask); end
`ifdef FETCH_REDIRECT_COUNT_EN
      tests++; if (redirect_count !== 32'd2) begin failed++; $display("FAIL tf_count: got %0d want 2", redirect_count); end
`endif
      @(negedge clk); #1;
      tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL tf_skid_flushed: got %0h want 0", ir_valid); end
   endtask

   task automatic test_redirect_resp();
      @(negedge clk); imem.imem_resp = 1'b1; imem.imem_rdata = 32'h0000_0033;
      br_mispredict = 1'b1; br_target = 32'h6000_0300; #1;
      tests++; if (pc_stall !== 1'b1) begin failed++; $display("FAIL rr_stall: got %0h want 1", pc_stall); end
      @(negedge clk); imem.imem_resp = 1'b0; br_mispredict = 1'b0; pc = 32'h6000_0300; #1;
      tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL rr_valid: got %0h want 0", ir_valid); end
      tests++; if (imem.imem_addr !== 32'h6000_0300) begin failed++; $display("FAIL rr_addr: got %h want 60000300", imem.imem_addr); end
      tests++; if (imem.imem_rmask !== 4'hF) begin failed++; $display("FAIL rr_rmask: got %h want f", imem.imem_rmask); end
   endtask

   task automatic test_reset_drop();
      @(negedge clk); br_mispredict = 1'b1; br_target = 32'h6000_0400; #1;
      @(negedge clk); br_mispredict = 1'b0; pc = 32'h6000_0400; #1;
      tests++; if (imem.imem_addr !== 32'h6000_0300) begin failed++; $display("FAIL rd_drop_addr: got %h want 60000300", imem.imem_addr); end
      #2 rst_n = 1'b0; #1;
      tests++; if (imem.imem_rmask !== 4'h0) begin failed++; $display("FAIL rd_rmask: got %h want 0", imem.imem_rmask); end
      tests++; if (imem.imem_addr !== 32'h0) begin failed++; $display("FAIL rd_addr: got %h want 0", imem.imem_addr); end
      tests++; if (pc_stall !== 1'b1) begin failed++; $display("FAIL rd_stall: got %0h want 1", pc_stall); end
`ifdef FETCH_REDIRECT_COUNT_EN
      tests++; if (redirect_count !== 32'd0) begin failed++; $display("FAIL rd_count: got %0d want 0", redirect_count); end
`endif
      @(negedge clk); rst_n = 1'b1; imem.imem_resp = 1'b1; imem.imem_rdata = 32'h0000_0044; #1;
      tests++; if (imem.imem_rmask !== 4'h0) begin failed++; $display("FAIL rd_idle_rmask: got %h want 0", imem.imem_rmask); end
      tests++; if (pc_stall !== 1'b1) begin failed++; $display("FAIL rd_idle_stall: got %0h want 1", pc_stall); end
      @(negedge clk); imem.imem_resp = 1'b0; #1;
      tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL rd_late_resp: got %0h want 0", ir_valid); end
      tests++; if (imem.imem_addr !== 32'h6000_0400) begin failed++; $display("FAIL rd_fetch_addr: got %h want 60000400", imem.imem_addr); end
      tests++; if (imem.imem_rmask !== 4'hF) begin failed++; $display("FAIL rd_fetch_rmask: got %h want f", imem.imem_rmask); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_skid();
      test_mispredict();
      test_trap_flush();
      test_redirect_resp();
      test_reset_drop();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
